// File: rtl/div_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpuDefine (package)
//  Description : Shared core definitions: ALU control codes, divider FSM
//                state encoding and small decode helpers for the divider.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpuDefine;

  // ALU operation select as produced by the decoder
  typedef enum logic [4:0] {
    ALU_ADD   = 5'd0,
    ALU_SUB   = 5'd1,
    ALU_SLT   = 5'd2,
    ALU_SLTU  = 5'd3,
    ALU_AND   = 5'd4,
    ALU_OR    = 5'd5,
    ALU_XOR   = 5'd6,
    ALU_NOR   = 5'd7,
    ALU_SLL   = 5'd8,
    ALU_SRL   = 5'd9,
    ALU_SRA   = 5'd10,
    ALU_LUI   = 5'd11,
    ALU_MUL   = 5'd12,
    ALU_MULH  = 5'd13,
    ALU_MULHU = 5'd14,
    ALU_DIV   = 5'd15,
    ALU_MOD   = 5'd16,
    ALU_DIVU  = 5'd17,
    ALU_MODU  = 5'd18
  } AluCtrl;

  // Divider sequencer states
  typedef enum logic [2:0] {
    DIV_IDLE = 3'd0,
    DIV_PREP = 3'd1,
    DIV_CALC = 3'd2,
    DIV_SIGN = 3'd3,
    DIV_DONE = 3'd4
  } DivState;

  // True for the four codes the divider services
  function automatic logic is_div_op(input AluCtrl c);
    return (c == ALU_DIV) || (c == ALU_MOD) || (c == ALU_DIVU) || (c == ALU_MODU);
  endfunction

  // True for the two's-complement variants
  function automatic logic is_signed_div_op(input AluCtrl c);
    return (c == ALU_DIV) || (c == ALU_MOD);
  endfunction

  // True when the remainder, not the quotient, is the result
  function automatic logic is_rem_op(input AluCtrl c);
    return (c == ALU_MOD) || (c == ALU_MODU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/div_sequencer_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_step
//  Description : One combinational radix-2 restoring division step.
//                {rem,quo} is shifted left by one, the divisor is trial-
//                subtracted from the widened partial remainder and the new
//                quotient bit is the inverted borrow.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_rem,
  output logic [WIDTH-1:0] next_quo
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           borrow;

  // Shift, trial-subtract one bit wider than the operands, restore on borrow
  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    diff     = shifted - {1'b0, divisor};
    borrow   = diff[WIDTH];
    next_rem = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    next_quo = {quo[WIDTH-2:0], ~borrow};
  end

endmodule
`default_nettype wire

// File: rtl/div_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : div_sequencer
//  Description : Multi-cycle DIV.W/MOD.W/DIVU.W/MODU.W controller. Sign
//                handling around an unsigned restoring core, one quotient
//                bit per cycle, pipeline stall while busy, one-cycle done.
//                Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the
//                iteration and finishes in the cycle after start.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_sequencer
  import cpuDefine::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  AluCtrl           aluctrl,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             flush,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  DivState          state_q,   state_d;
  logic [WIDTH-1:0] rem_q,     rem_d;
  logic [WIDTH-1:0] quo_q,     quo_d;
  logic [WIDTH-1:0] dvd_mag_q, dvd_mag_d;
  logic [WIDTH-1:0] dvs_mag_q, dvs_mag_d;
  logic             dvd_neg_q, dvd_neg_d;
  logic             dvs_neg_q, dvs_neg_d;
  logic             rem_op_q,  rem_op_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [WIDTH-1:0] result_q,  result_d;
  logic             done_q,    done_d;

  logic             accept;
  logic             op_signed;
  logic             src1_neg;
  logic             src2_neg;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;
  logic [WIDTH-1:0] dividend_raw;
  logic [WIDTH-1:0] quo_signed;
  logic [WIDTH-1:0] rem_signed;

  // Single restoring-step datapath, only consumed while iterating
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvs_mag_q),
    .next_rem (step_rem),
    .next_quo (step_quo)
  );

  // Request decode, operand sign/magnitude and final sign correction
  always_comb begin
    accept       = (state_q == DIV_IDLE) & start & is_div_op(aluctrl) & ~flush;
    op_signed    = is_signed_div_op(aluctrl);
    src1_neg     = op_signed & src1[WIDTH-1];
    src2_neg     = op_signed & src2[WIDTH-1];
    // The original dividend is rebuilt from sign and magnitude for x/0
    dividend_raw = dvd_neg_q ? (~dvd_mag_q + 1'b1) : dvd_mag_q;
    quo_signed   = (dvd_neg_q ^ dvs_neg_q) ? (~quo_q + 1'b1) : quo_q;
    rem_signed   = dvd_neg_q ? (~rem_q + 1'b1) : rem_q;
  end

  // Stall covers the accepting cycle and all busy states, never a flush cycle
  always_comb begin
    stall = ~flush & (accept | (state_q == DIV_PREP) | (state_q == DIV_CALC) |
                      (state_q == DIV_SIGN));
  end

  // Next-state and datapath updates for the sequencer
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvd_mag_d = dvd_mag_q;
    dvs_mag_d = dvs_mag_q;
    dvd_neg_d = dvd_neg_q;
    dvs_neg_d = dvs_neg_q;
    rem_op_d  = rem_op_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    done_d    = 1'b0;

    unique case (state_q)
      DIV_IDLE: begin
        if (accept) begin
          rem_op_d  = is_rem_op(aluctrl);
          dvd_neg_d = src1_neg;
          dvs_neg_d = src2_neg;
          dvd_mag_d = src1_neg ? (~src1 + 1'b1) : src1;
          dvs_mag_d = src2_neg ? (~src2 + 1'b1) : src2;
`ifdef DIV_ZERO_FAST_EN
          if (src2 == '0) begin
            result_d = is_rem_op(aluctrl) ? src1 : '1;
            done_d   = 1'b1;
            state_d  = DIV_DONE;
          end else begin
            state_d  = DIV_PREP;
          end
`else
          state_d   = DIV_PREP;
`endif
        end
      end
      DIV_PREP: begin
        rem_d   = '0;
        quo_d   = dvd_mag_q;
        cnt_d   = CNT_W'(WIDTH);
        state_d = DIV_CALC;
      end
      DIV_CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = DIV_SIGN;
        end
      end
      DIV_SIGN: begin
        // Zero divisor has fixed architectural results regardless of sign
        if (dvs_mag_q == '0) begin
          result_d = rem_op_q ? dividend_raw : '1;
        end else begin
          result_d = rem_op_q ? rem_signed : quo_signed;
        end
        done_d  = 1'b1;
        state_d = DIV_DONE;
      end
      DIV_DONE: begin
        state_d = DIV_IDLE;
      end
      default: begin
        state_d = DIV_IDLE;
      end
    endcase

    // A redirect abandons the op: back to idle, keep the previous result
    if (flush && (state_q != DIV_IDLE)) begin
      state_d  = DIV_IDLE;
      done_d   = 1'b0;
      result_d = result_q;
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DIV_IDLE;
      rem_q     <= '0;
      quo_q     <= '0;
      dvd_mag_q <= '0;
      dvs_mag_q <= '0;
      dvd_neg_q <= 1'b0;
      dvs_neg_q <= 1'b0;
      rem_op_q  <= 1'b0;
      cnt_q     <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvd_mag_q <= dvd_mag_d;
      dvs_mag_q <= dvs_mag_d;
      dvd_neg_q <= dvd_neg_d;
      dvs_neg_q <= dvs_neg_d;
      rem_op_q  <= rem_op_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      done_q    <= done_d;
    end
  end

  assign done   = done_q;
  assign result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_div_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_sequencer
//  Description : Self-checking bench for div_sequencer. A reference model
//                computes each result with 64-bit integer arithmetic and the
//                expected stall/done window from the op latency; a compare
//                process checks stall, done and result every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_sequencer;
  import cpuDefine::*;

  localparam int W = 32;

  logic         clk     = 1'b0;
  logic         rst     = 1'b1;
  logic         start   = 1'b0;
  logic         flush   = 1'b0;
  AluCtrl       aluctrl = ALU_ADD;
  logic [W-1:0] src1    = '0;
  logic [W-1:0] src2    = '0;
  logic         stall;
  logic         done;
  logic [W-1:0] result;

  div_sequencer #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .aluctrl (aluctrl),
    .src1    (src1),
    .src2    (src2),
    .flush   (flush),
    .stall   (stall),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model state (written only by the stimulus process)
  bit           chk_en   = 1'b0;
  bit           m_active = 1'b0;
  int           m_start  = 0;
  int           m_done   = 0;
  logic [W-1:0] m_val    = '0;
  logic [W-1:0] m_hold   = '0;
  bit           lit_en   = 1'b0;
  logic [W-1:0] lit_val  = '0;

  int checks = 0;
  int errors = 0;

  AluCtrl ops[4] = '{ALU_DIV, ALU_MOD, ALU_DIVU, ALU_MODU};

  // Architectural result from plain integer arithmetic
  function automatic logic [W-1:0] ref_div(input AluCtrl op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    longint       sa, sb, sq;
    logic [63:0]  ua, ub, t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (b == '0) return ((op == ALU_MOD) || (op == ALU_MODU)) ? a : 32'hFFFF_FFFF;
    case (op)
      ALU_DIV:  sq = sa / sb;
      ALU_MOD:  sq = sa % sb;
      ALU_DIVU: sq = longint'(ua / ub);
      default:  sq = longint'(ua % ub);
    endcase
    t = 64'(sq);
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 20));
      5:       return 32'h7FFF_FFFF;
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Compare process: DUT outputs against the model every cycle
  always @(negedge clk) begin
    logic         e_done;
    logic         e_stall;
    logic [W-1:0] e_res;
    if (chk_en) begin
      e_done  = m_active && (cyc == m_done) && !flush;
      e_stall = m_active && (cyc >= m_start) && (cyc < m_done) && !flush;
      e_res   = e_done ? m_val : m_hold;
      check("stall",  {31'd0, stall}, {31'd0, e_stall});
      check("done",   {31'd0, done},  {31'd0, e_done});
      check("result", result, e_res);
      if (e_done && lit_en) begin
        check("literal_result", result, lit_val);
        check("literal_model",  m_val,  lit_val);
      end
    end
  end

  // Issue one op; optionally abort it with flush or reset abort_at cycles after start
  task automatic do_op(input AluCtrl op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int abort_at, input bit use_rst,
                       input bit le, input logic [W-1:0] lv);
    int lat;
    bit fin;
    @(posedge clk); #1;
    start   = 1'b1;
    aluctrl = op;
    src1    = a;
    src2    = b;
    flush   = 1'b0;
    lat     = 35;
`ifdef DIV_ZERO_FAST_EN
    if (b == '0) lat = 1;
`endif
    m_start  = cyc;
    m_done   = cyc + lat;
    m_val    = ref_div(op, a, b);
    lit_en   = le;
    lit_val  = lv;
    m_active = 1'b1;
    fin      = 1'b0;
    while (!fin) begin
      @(posedge clk); #1;
      start = 1'b0;
      if ((abort_at > 0) && (cyc == m_start + abort_at)) begin
        if (use_rst) rst = 1'b1;
        else         flush = 1'b1;
        start   = 1'($urandom_range(0, 1));
        aluctrl = ops[$urandom_range(0, 3)];
        @(posedge clk); #1;
        rst      = 1'b0;
        flush    = 1'b0;
        start    = 1'b0;
        m_active = 1'b0;
        lit_en   = 1'b0;
        if (use_rst) m_hold = '0;
        fin = 1'b1;
      end else if (cyc == m_done) begin
        m_hold = m_val;
        fin    = 1'b1;
      end else begin
        // Busy-cycle noise: starts and operand changes must be ignored
        start   = 1'($urandom_range(0, 1));
        aluctrl = ops[$urandom_range(0, 3)];
        src1    = 32'($urandom);
        src2    = 32'($urandom);
      end
    end
  endtask

  // Idle cycles with non-divide starts and harmless flushes
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      start   = 1'($urandom_range(0, 1));
      aluctrl = ALU_ADD;
      flush   = ($urandom_range(0, 3) == 0);
      src1    = 32'($urandom);
      src2    = 32'($urandom);
    end
    @(posedge clk); #1;
    start = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    AluCtrl       op;
    logic [W-1:0] a, b;
    int           ab;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    chk_en = 1'b1;

    do_op(ALU_DIVU, 32'd100, 32'd7, 0, 0, 1, 32'd14);
    do_op(ALU_MODU, 32'd100, 32'd7, 0, 0, 1, 32'd2);
    do_op(ALU_DIV,  32'hFFFF_FFF9, 32'd2, 0, 0, 1, 32'hFFFF_FFFD);
    do_op(ALU_MOD,  32'hFFFF_FFF9, 32'd2, 0, 0, 1, 32'hFFFF_FFFF);
    do_op(ALU_MOD,  32'd7, 32'hFFFF_FFFE, 0, 0, 1, 32'd1);
    do_op(ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1, 32'h8000_0000);
    do_op(ALU_MOD,  32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1, 32'h0000_0000);
    do_op(ALU_DIVU, 32'd5, 32'd0, 0, 0, 1, 32'hFFFF_FFFF);
    do_op(ALU_MOD,  32'hFFFF_FFFB, 32'd0, 0, 0, 1, 32'hFFFF_FFFB);
    do_op(ALU_DIV,  32'hFFFF_FFFB, 32'd0, 0, 0, 1, 32'hFFFF_FFFF);
    do_op(ALU_MODU, 32'd5, 32'd0, 0, 0, 1, 32'd5);
    idle_cycles(4);

    // Flush in CALC, then a fresh op
    do_op(ALU_DIVU, 32'h1234_5678, 32'd5, 10, 0, 0, '0);
    do_op(ALU_DIVU, 32'd9, 32'd3, 0, 0, 1, 32'd3);
    // Reset in CALC, then a fresh op
    do_op(ALU_DIV, 32'd1000, 32'd7, 10, 1, 0, '0);
    do_op(ALU_DIVU, 32'd9, 32'd3, 0, 0, 1, 32'd3);
    idle_cycles(5);

    for (int n = 0; n < 120; n++) begin
      op = ops[$urandom_range(0, 3)];
      a  = pick();
      b  = pick();
      ab = 0;
      if ((b != '0) && ($urandom_range(0, 14) == 0)) ab = $urandom_range(1, 34);
      do_op(op, a, b, ab, 1'($urandom_range(0, 1)), 0, '0);
      if ($urandom_range(0, 5) == 0) idle_cycles($urandom_range(1, 4));
    end

    idle_cycles(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
